// File: rtl/fetch_mem_ctrl.sv
// fetch_mem_ctrl
//   Sequencer for a simple load/store CPU. It fetches an instruction over a
//   slow asynchronous SRAM (PC -> MAR, SRAM -> MDR -> IR). It then hands
//   control to the execute unit. While the execute unit runs, it serves that
//   unit's data reads and writes. Every output is a registered decode of the
//   next state and next wait count, so each output is a clean Moore function
//   of the current state and counter.
//
// Parameters
//   WAIT_CYCLES  cycles each SRAM access holds its strobes (1..15)
//
// Ports
//   Clk          sole clock, rising edge
//   Reset        asynchronous active-low reset
//   Run, Halt    fetch permission / stop at the next instruction boundary
//   Exec_Done    execute unit finished the current instruction
//   Mem_Req      execute unit data access request (address already in MAR)
//   Mem_WE       1 = write from MDR, 0 = read into MDR
//   LDMAR/LDMDR/LDPC/LDIR  register load enables
//   PCMUX        PC source select (00 = PC+1)
//   MIOEN        1 = MDR loads from memory
//   GatePC/GateMDR  bus gates
//   CE/OE/WE     active-low SRAM strobes
//   Mem_Ack      one-cycle pulse, data access complete
//   Instr_Valid  one-cycle pulse, IR holds a new instruction
//   State        current state encoding (debug)
module fetch_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Halt,
  input  logic       Exec_Done,
  input  logic       Mem_Req,
  input  logic       Mem_WE,
  output logic       LDMAR,
  output logic       LDMDR,
  output logic       LDPC,
  output logic       LDIR,
  output logic [1:0] PCMUX,
  output logic       MIOEN,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       CE,
  output logic       OE,
  output logic       WE,
  output logic       Mem_Ack,
  output logic       Instr_Valid,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F1   = 3'd1,
    S_F2   = 3'd2,
    S_F3   = 3'd3,
    S_EXEC = 3'd4,
    S_RD   = 3'd5,
    S_WR   = 3'd6
  } state_e;

  typedef struct packed {
    logic       ldmar;
    logic       ldmdr;
    logic       ldpc;
    logic       ldir;
    logic [1:0] pcmux;
    logic       mioen;
    logic       gatepc;
    logic       gatemdr;
    logic       ce;
    logic       oe;
    logic       we;
    logic       mem_ack;
  } ctl_t;

  // The counter counts down to 0, so an N-cycle access loads N-1.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctl_t       ctl_q;
  logic       instr_valid_q;

  // Control word for a given state and wait count. Strobes idle high.
  function automatic ctl_t decode(input state_e s, input logic [3:0] cnt);
    ctl_t c;
    c    = '0;
    c.ce = 1'b1;
    c.oe = 1'b1;
    c.we = 1'b1;
    case (s)
      S_F1: begin
        c.gatepc = 1'b1;
        c.ldmar  = 1'b1;
        c.ldpc   = 1'b1;
      end
      S_F2: begin
        c.ce    = 1'b0;
        c.oe    = 1'b0;
        c.mioen = 1'b1;
        c.ldmdr = (cnt == 4'd0);
      end
      S_F3: begin
        c.gatemdr = 1'b1;
        c.ldir    = 1'b1;
      end
      S_RD: begin
        c.ce      = 1'b0;
        c.oe      = 1'b0;
        c.mioen   = 1'b1;
        c.ldmdr   = (cnt == 4'd0);
        c.mem_ack = (cnt == 4'd0);
      end
      S_WR: begin
        c.ce      = 1'b0;
        c.we      = 1'b0;
        c.mem_ack = (cnt == 4'd0);
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (Run && !Halt) state_d = S_F1;
      S_F1: begin
        state_d = S_F2;
        cnt_d   = CNT_LOAD;
      end
      S_F2: begin
        if (cnt_q == 4'd0) state_d = S_F3;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_F3: state_d = S_EXEC;
      S_EXEC: begin
        // A data request takes priority over Exec_Done. The requester keeps
        // Exec_Done asserted, and it is seen once the access returns here.
        if (Mem_Req) begin
          state_d = Mem_WE ? S_WR : S_RD;
          cnt_d   = CNT_LOAD;
        end else if (Exec_Done) begin
          state_d = (Halt || !Run) ? S_IDLE : S_F1;
        end
      end
      S_RD, S_WR: begin
        if (cnt_q == 4'd0) state_d = S_EXEC;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode. As a result they
  // track state_q exactly, and reset clears them together with the state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      ctl_q         <= decode(S_IDLE, 4'd0);
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ctl_q         <= decode(state_d, cnt_d);
      // Only a fresh fetch (F3 -> EXEC) flags a new instruction. Returning
      // to EXEC from a data access does not.
      instr_valid_q <= (state_q == S_F3) && (state_d == S_EXEC);
    end
  end

  assign LDMAR       = ctl_q.ldmar;
  assign LDMDR       = ctl_q.ldmdr;
  assign LDPC        = ctl_q.ldpc;
  assign LDIR        = ctl_q.ldir;
  assign PCMUX       = ctl_q.pcmux;
  assign MIOEN       = ctl_q.mioen;
  assign GatePC      = ctl_q.gatepc;
  assign GateMDR     = ctl_q.gatemdr;
  assign CE          = ctl_q.ce;
  assign OE          = ctl_q.oe;
  assign WE          = ctl_q.we;
  assign Mem_Ack     = ctl_q.mem_ack;
  assign Instr_Valid = instr_valid_q;
  assign State       = state_q;

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// Directed bench for fetch_mem_ctrl. The main instance uses the default
// WAIT_CYCLES=2. Two more instances (WAIT_CYCLES=1 and 15) measure how many
// cycles each access state lasts.
module tb_fetch_mem_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  // main instance
  logic       Reset, Run, Halt, Exec_Done, Mem_Req, Mem_WE;
  logic       LDMAR, LDMDR, LDPC, LDIR, MIOEN, GatePC, GateMDR, CE, OE, WE, Mem_Ack, Instr_Valid;
  logic [1:0] PCMUX;
  logic [2:0] State;
  wire  [14:0] outs = {LDMAR, LDMDR, LDPC, LDIR, PCMUX, MIOEN, GatePC, GateMDR,
                       CE, OE, WE, Mem_Ack, Instr_Valid};

  fetch_mem_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Halt(Halt), .Exec_Done(Exec_Done),
    .Mem_Req(Mem_Req), .Mem_WE(Mem_WE),
    .LDMAR(LDMAR), .LDMDR(LDMDR), .LDPC(LDPC), .LDIR(LDIR), .PCMUX(PCMUX),
    .MIOEN(MIOEN), .GatePC(GatePC), .GateMDR(GateMDR), .CE(CE), .OE(OE), .WE(WE),
    .Mem_Ack(Mem_Ack), .Instr_Valid(Instr_Valid), .State(State)
  );

  // wait-cycle instances, shared stimulus
  logic        w_rst_n, w_run, w_req, w_we;
  wire  [14:0] o1, o15;
  wire  [2:0]  s1, s15;
  wire  [1:0]  pm1, pm15;

  fetch_mem_ctrl #(.WAIT_CYCLES(1)) dut_w1 (
    .Clk(Clk), .Reset(w_rst_n), .Run(w_run), .Halt(1'b0), .Exec_Done(1'b0),
    .Mem_Req(w_req), .Mem_WE(w_we),
    .LDMAR(o1[14]), .LDMDR(o1[13]), .LDPC(o1[12]), .LDIR(o1[11]), .PCMUX(pm1),
    .MIOEN(o1[8]), .GatePC(o1[7]), .GateMDR(o1[6]), .CE(o1[5]), .OE(o1[4]), .WE(o1[3]),
    .Mem_Ack(o1[2]), .Instr_Valid(o1[1]), .State(s1)
  );
  assign o1[10:9] = pm1;
  assign o1[0]    = 1'b0;

  fetch_mem_ctrl #(.WAIT_CYCLES(15)) dut_w15 (
    .Clk(Clk), .Reset(w_rst_n), .Run(w_run), .Halt(1'b0), .Exec_Done(1'b0),
    .Mem_Req(w_req), .Mem_WE(w_we),
    .LDMAR(o15[14]), .LDMDR(o15[13]), .LDPC(o15[12]), .LDIR(o15[11]), .PCMUX(pm15),
    .MIOEN(o15[8]), .GatePC(o15[7]), .GateMDR(o15[6]), .CE(o15[5]), .OE(o15[4]), .WE(o15[3]),
    .Mem_Ack(o15[2]), .Instr_Valid(o15[1]), .State(s15)
  );
  assign o15[10:9] = pm15;
  assign o15[0]    = 1'b0;

  // Run-length monitors: length of the most recent visit to each state.
  logic [2:0] pv1 = 3'd0, pv15 = 3'd0;
  int rn1 = 0, rn15 = 0, ack15 = 0;
  int len1 [8];
  int len15 [8];

  always @(negedge Clk) begin
    if (s1 == pv1) rn1 <= rn1 + 1;
    else begin
      len1[pv1] <= rn1;
      pv1       <= s1;
      rn1       <= 1;
    end
    if (s15 == pv15) rn15 <= rn15 + 1;
    else begin
      len15[pv15] <= rn15;
      pv15        <= s15;
      rn15        <= 1;
    end
    if (o15[2]) ack15 <= ack15 + 1;
  end

  // Expected control words, bit order as 'outs':
  // LDMAR LDMDR LDPC LDIR PCMUX[1:0] MIOEN GatePC GateMDR CE OE WE Mem_Ack Instr_Valid
  localparam logic [14:0] P_IDLE = 15'b0_0_0_0_00_0_0_0_1_1_1_0_0;
  localparam logic [14:0] P_F1   = 15'b1_0_1_0_00_0_1_0_1_1_1_0_0;
  localparam logic [14:0] P_RDA  = 15'b0_0_0_0_00_1_0_0_0_0_1_0_0;
  localparam logic [14:0] P_F2L  = 15'b0_1_0_0_00_1_0_0_0_0_1_0_0;
  localparam logic [14:0] P_F3   = 15'b0_0_0_1_00_0_0_1_1_1_1_0_0;
  localparam logic [14:0] P_EXV  = 15'b0_0_0_0_00_0_0_0_1_1_1_0_1;
  localparam logic [14:0] P_RDL  = 15'b0_1_0_0_00_1_0_0_0_0_1_1_0;
  localparam logic [14:0] P_WRA  = 15'b0_0_0_0_00_0_0_0_0_1_0_0_0;
  localparam logic [14:0] P_WRL  = 15'b0_0_0_0_00_0_0_0_0_1_0_1_0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, then check state and the full control word.
  task automatic step_chk(input string tag, input logic [2:0] st, input logic [14:0] pat);
    @(negedge Clk);
    check({tag, "_state"}, 32'(State), 32'(st));
    check({tag, "_out"}, 32'(outs), 32'(pat));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    Reset = 1'b0; Run = 1'b0; Halt = 1'b0; Exec_Done = 1'b0; Mem_Req = 1'b0; Mem_WE = 1'b0;
    w_rst_n = 1'b0; w_run = 1'b0; w_req = 1'b0; w_we = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_state", 32'(State), 32'd0);
    check("rst_out", 32'(outs), 32'(P_IDLE));

    // release with Run=0: must stay idle
    Reset = 1'b1;
    step_chk("idle_norun", 3'd0, P_IDLE);
    Run = 1'b1;

    // fetch: F1, F2 x2 (LDMDR in 2nd), F3, EXEC with Instr_Valid
    step_chk("f1", 3'd1, P_F1);
    step_chk("f2a", 3'd2, P_RDA);
    step_chk("f2b", 3'd2, P_F2L);
    step_chk("f3", 3'd3, P_F3);
    step_chk("exec_iv", 3'd4, P_EXV);
    step_chk("exec_hold", 3'd4, P_IDLE);

    // data read
    Mem_Req = 1'b1; Mem_WE = 1'b0;
    step_chk("rd_a", 3'd5, P_RDA);
    Mem_Req = 1'b0;
    step_chk("rd_b", 3'd5, P_RDL);
    step_chk("rd_ret", 3'd4, P_IDLE);

    // data write
    Mem_Req = 1'b1; Mem_WE = 1'b1;
    step_chk("wr_a", 3'd6, P_WRA);
    Mem_Req = 1'b0;
    step_chk("wr_b", 3'd6, P_WRL);
    step_chk("wr_ret", 3'd4, P_IDLE);

    // request held through Ack becomes a second request
    Mem_Req = 1'b1; Mem_WE = 1'b0;
    step_chk("b2b_rd1a", 3'd5, P_RDA);
    step_chk("b2b_rd1b", 3'd5, P_RDL);
    step_chk("b2b_exec", 3'd4, P_IDLE);
    step_chk("b2b_rd2a", 3'd5, P_RDA);
    Mem_Req = 1'b0;
    step_chk("b2b_rd2b", 3'd5, P_RDL);
    step_chk("b2b_ret", 3'd4, P_IDLE);

    // Mem_Req beats Exec_Done; held Exec_Done with Halt=1 -> IDLE
    Mem_Req = 1'b1; Exec_Done = 1'b1; Halt = 1'b1;
    step_chk("prio_rda", 3'd5, P_RDA);
    Mem_Req = 1'b0;
    step_chk("prio_rdb", 3'd5, P_RDL);
    step_chk("prio_exec", 3'd4, P_IDLE);
    step_chk("halt_idle", 3'd0, P_IDLE);
    step_chk("halt_stay", 3'd0, P_IDLE);
    Halt = 1'b0;

    // Exec_Done ignored outside EXEC; at EXEC with Halt=0 -> F1
    step_chk("rf1", 3'd1, P_F1);
    step_chk("rf2a", 3'd2, P_RDA);
    step_chk("rf2b", 3'd2, P_F2L);
    step_chk("rf3", 3'd3, P_F3);
    step_chk("rexec_iv", 3'd4, P_EXV);
    step_chk("done_f1", 3'd1, P_F1);
    Exec_Done = 1'b0;
    step_chk("r2_f2a", 3'd2, P_RDA);
    step_chk("r2_f2b", 3'd2, P_F2L);

    // reset in 2nd F2 cycle: strobes drop before the next edge
    #2 Reset = 1'b0;
    #1;
    check("async_state", 32'(State), 32'd0);
    check("async_ce", 32'(CE), 32'd1);
    check("async_oe", 32'(OE), 32'd1);
    check("async_out", 32'(outs), 32'(P_IDLE));
    @(negedge Clk);
    check("rst_hold_out", 32'(outs), 32'(P_IDLE));
    Run = 1'b0;
    Reset = 1'b1;
    step_chk("rel_norun", 3'd0, P_IDLE);

    // Mem_Req is ignored during fetch and is honoured at EXEC
    Run = 1'b1; Mem_Req = 1'b1; Mem_WE = 1'b1;
    step_chk("l_f1", 3'd1, P_F1);
    step_chk("l_f2a", 3'd2, P_RDA);
    step_chk("l_f2b", 3'd2, P_F2L);
    step_chk("l_f3", 3'd3, P_F3);
    step_chk("l_exec_iv", 3'd4, P_EXV);
    step_chk("late_wra", 3'd6, P_WRA);
    Mem_Req = 1'b0; Run = 1'b0;
    step_chk("late_wrb", 3'd6, P_WRL);
    step_chk("late_ret", 3'd4, P_IDLE);
    Exec_Done = 1'b1;
    step_chk("run0_idle", 3'd0, P_IDLE);
    Exec_Done = 1'b0;

    // WAIT_CYCLES = 1 / 15 duration measurements
    w_rst_n = 1'b1; w_run = 1'b1;
    k = 0;
    while (!(s1 == 3'd4 && s15 == 3'd4) && k < 100) begin
      @(negedge Clk);
      k++;
    end
    check("w_fetch_timeout", 32'(k < 100), 32'd1);

    w_req = 1'b1; w_we = 1'b0;
    k = 0;
    while (!o15[2] && k < 40) begin
      @(negedge Clk);
      k++;
    end
    check("w_rd_timeout", 32'(k < 40), 32'd1);
    w_req = 1'b0;
    repeat (3) @(negedge Clk);

    w_req = 1'b1; w_we = 1'b1;
    k = 0;
    while (!o15[2] && k < 40) begin
      @(negedge Clk);
      k++;
    end
    check("w_wr_timeout", 32'(k < 40), 32'd1);
    w_req = 1'b0;
    repeat (3) @(negedge Clk);

    check("w1_f2_len", 32'(len1[2]), 32'd1);
    check("w15_f2_len", 32'(len15[2]), 32'd15);
    check("w1_rd_len", 32'(len1[5]), 32'd1);
    check("w15_rd_len", 32'(len15[5]), 32'd15);
    check("w1_wr_len", 32'(len1[6]), 32'd1);
    check("w15_wr_len", 32'(len15[6]), 32'd15);
    check("w15_ack_cnt", 32'(ack15), 32'd2);
    check("w_exec_both", 32'({s1, s15}), 32'({3'd4, 3'd4}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
